// File: rtl/state_seq_pkg.sv
// state_seq_pkg: shared state indices, sequencer phases and request layout for the
// MERA-400 main-loop state sequencer.
package state_seq_pkg;

    localparam int NST = 13;

    // State index doubles as request priority: the lowest set index wins.
    localparam int K2 = 0;
    localparam int K1 = 1;
    localparam int P0 = 2;
    localparam int P1 = 3;
    localparam int P2 = 4;
    localparam int P3 = 5;
    localparam int P4 = 6;
    localparam int P5 = 7;
    localparam int I1 = 8;
    localparam int I2 = 9;
    localparam int I3 = 10;
    localparam int I4 = 11;
    localparam int I5 = 12;

    typedef logic [NST-1:0] req_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_S1,
        PH_MW,
        PH_S2,
        PH_GOT
    } phase_e;

    function automatic req_t first_req(req_t r);
        return r & (~r + req_t'(1));
    endfunction

endpackage

// File: rtl/state_seq_if.sv
// state_seq_if: request inputs, one-hot state and phase strobes between the
// microinstruction unit (master) and the state sequencer (slave).
interface state_seq_if;
    logic run, stp0, ss, mem_req, mem_ok;
    logic ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ei1, ei2, ei3, ei4, ei5;
    logic k1, k2, p0, p1, p2, p3, p4, p5, i1, i2, i3, i4, i5;
    logic strob1, strob2, got, alarm;

    modport master (
        output run, stp0, ss, mem_req, mem_ok,
        output ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ei1, ei2, ei3, ei4, ei5,
        input  k1, k2, p0, p1, p2, p3, p4, p5, i1, i2, i3, i4, i5,
        input  strob1, strob2, got, alarm
    );

    modport slave (
        input  run, stp0, ss, mem_req, mem_ok,
        input  ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ei1, ei2, ei3, ei4, ei5,
        output k1, k2, p0, p1, p2, p3, p4, p5, i1, i2, i3, i4, i5,
        output strob1, strob2, got, alarm
    );
endinterface

// File: rtl/state_seq_strob_seq.sv
// strob_seq: phase FSM (IDLE/S1/MW/S2/GOT), phase counter and optional memory-wait
// watchdog enabled by STATE_SEQ_WATCHDOG_EN.
module strob_seq
    import state_seq_pkg::*;
#(
    parameter int S1_CYC      = 2,
    parameter int S2_CYC      = 2,
    parameter int GOT_CYC     = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic ss_i,
    input  logic mem_req_i,
    input  logic mem_ok_i,
    output logic strob1_o,
    output logic strob2_o,
    output logic got_o,
    output logic end_o,
    output logic alarm_o
);
    localparam logic [3:0] L1 = 4'(S1_CYC - 1);
    localparam logic [3:0] L2 = 4'(S2_CYC - 1);
    localparam logic [3:0] LG = 4'(GOT_CYC - 1);

    phase_e     ph_q, ph_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ss_q, ss_d;
    logic       last, mw_done;

    assign last = cnt_q == 4'd0;

`ifdef STATE_SEQ_WATCHDOG_EN
    logic [9:0] wcnt_q, wcnt_d;
    logic       tmo, alarm_q;

    assign tmo     = ph_q == PH_MW && !mem_ok_i && wcnt_q == 10'(MEM_TIMEOUT - 1);
    assign wcnt_d  = ph_q == PH_MW ? wcnt_q + 10'd1 : 10'd0;
    assign mw_done = mem_ok_i | tmo;
    assign alarm_o = alarm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            alarm_q <= tmo;
        end
    end
`else
    assign mw_done = mem_ok_i;
    assign alarm_o = 1'b0;
`endif

    // Counter idles at 0 outside timed phases so IDLE/MW simply hold it.
    always_comb begin
        ph_d  = ph_q;
        cnt_d = last ? cnt_q : cnt_q - 4'd1;
        ss_d  = ss_q;
        case (ph_q)
            PH_IDLE: if (start_i) begin
                ph_d  = PH_S1;
                cnt_d = L1;
            end
            PH_S1: if (last) begin
                ss_d  = ss_i;
                ph_d  = mem_req_i ? PH_MW : ss_i ? PH_S2 : PH_GOT;
                cnt_d = mem_req_i ? 4'd0 : ss_i ? L2 : LG;
            end
            PH_MW: if (mw_done) begin
                ph_d  = ss_q ? PH_S2 : PH_GOT;
                cnt_d = ss_q ? L2 : LG;
            end
            PH_S2: if (last) begin
                ph_d  = PH_GOT;
                cnt_d = LG;
            end
            PH_GOT: ph_d = last ? PH_IDLE : PH_GOT;
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= PH_IDLE;
            cnt_q <= '0;
            ss_q  <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            ss_q  <= ss_d;
        end
    end

    assign strob1_o = ph_q == PH_S1;
    assign strob2_o = ph_q == PH_S2;
    assign got_o    = ph_q == PH_GOT;
    assign end_o    = ph_q == PH_GOT && last;

endmodule

// File: rtl/state_seq.sv
// state_seq: MERA-400 one-hot main-loop state register with priority request encoder;
// strobe timing lives in strob_seq (memory watchdog via STATE_SEQ_WATCHDOG_EN).
module state_seq
    import state_seq_pkg::*;
#(
    parameter int S1_CYC      = 2,
    parameter int S2_CYC      = 2,
    parameter int GOT_CYC     = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input logic  clk,
    input logic  clm_n,
    state_seq_if.slave bus
);
    req_t req, st_q, st_d;
    logic cyc_end, start;

    assign req = {bus.ei5, bus.ei4, bus.ei3, bus.ei2, bus.ei1,
                  bus.ep5, bus.ep4, bus.ep3, bus.ep2, bus.ep1, bus.ep0,
                  bus.ek1, bus.ek2};

    // No request means the current state repeats.
    assign st_d  = cyc_end ? (req == '0 ? st_q : first_req(req)) : st_q;
    assign start = !(st_q[P0] && bus.stp0 && !bus.run);

    always_ff @(posedge clk or negedge clm_n) begin
        if (!clm_n) st_q <= req_t'(1) << P0;
        else        st_q <= st_d;
    end

    strob_seq #(
        .S1_CYC     (S1_CYC),
        .S2_CYC     (S2_CYC),
        .GOT_CYC    (GOT_CYC),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_seq (
        .clk      (clk),
        .rst_n    (clm_n),
        .start_i  (start),
        .ss_i     (bus.ss),
        .mem_req_i(bus.mem_req),
        .mem_ok_i (bus.mem_ok),
        .strob1_o (bus.strob1),
        .strob2_o (bus.strob2),
        .got_o    (bus.got),
        .end_o    (cyc_end),
        .alarm_o  (bus.alarm)
    );

    assign bus.k2 = st_q[K2];
    assign bus.k1 = st_q[K1];
    assign bus.p0 = st_q[P0];
    assign bus.p1 = st_q[P1];
    assign bus.p2 = st_q[P2];
    assign bus.p3 = st_q[P3];
    assign bus.p4 = st_q[P4];
    assign bus.p5 = st_q[P5];
    assign bus.i1 = st_q[I1];
    assign bus.i2 = st_q[I2];
    assign bus.i3 = st_q[I3];
    assign bus.i4 = st_q[I4];
    assign bus.i5 = st_q[I5];

endmodule
